// File: rtl/msrh_sched_entry_multi_src.sv
// msrh_sched_entry_multi_src: one issue-queue slot with NUM_SRC operands,
// speculative wakeup, cancel-driven replay and branch/flush kill.
module msrh_sched_entry_multi_src #(
  parameter int NUM_SRC    = 3,
  parameter int WAKE_NUM   = 4,
  parameter int CANCEL_NUM = 2,
  parameter int RNID_W     = 7,
  parameter int CMT_ID_W   = 6,
  parameter int BR_W       = 8,
  parameter int REPLAY_MAX = 3,
  localparam int RC_W  = $clog2(REPLAY_MAX+1),
  localparam int TAG_W = $clog2(BR_W)
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_put,
  input  logic [CMT_ID_W-1:0]          i_put_cmt_id,
  input  logic [NUM_SRC-1:0]           i_put_src_valid,
  input  logic [NUM_SRC*RNID_W-1:0]    i_put_src_rnid,
  input  logic [NUM_SRC-1:0]           i_put_src_ready,
  input  logic [BR_W-1:0]              i_put_br_mask,
  input  logic [WAKE_NUM-1:0]          i_wake_valid,
  input  logic [WAKE_NUM*RNID_W-1:0]   i_wake_rnid,
  input  logic [WAKE_NUM-1:0]          i_wake_spec,
  input  logic [CANCEL_NUM-1:0]        i_cancel_valid,
  input  logic [CANCEL_NUM*RNID_W-1:0] i_cancel_rnid,
  input  logic                         i_picked,
  input  logic                         i_pipe_done,
  input  logic                         i_pipe_except,
  input  logic                         i_commit,
  input  logic [CMT_ID_W-1:0]          i_commit_cmt_id,
  input  logic                         i_flush,
  input  logic                         i_br_upd,
  input  logic [TAG_W-1:0]             i_br_tag,
  input  logic                         i_br_mispred,
  output logic                         o_valid,
  output logic                         o_ready,
  output logic [NUM_SRC-1:0]           o_src_ready,
  output logic                         o_done,
  output logic                         o_finish,
  output logic                         o_except,
  output logic [RC_W-1:0]              o_replay_cnt,
  output logic [CMT_ID_W-1:0]          o_cmt_id
);

  typedef enum logic [2:0] {
    S_INIT, S_WAIT, S_ISSUED, S_DONE, S_WCMP, S_DEAD
  } state_t;

  state_t                    state_q;
  logic                      valid_q;
  logic [CMT_ID_W-1:0]       cmt_id_q;
  logic [NUM_SRC-1:0]        src_valid_q;
  logic [NUM_SRC*RNID_W-1:0] src_rnid_q;
  logic [NUM_SRC-1:0]        ready_q;
  logic [NUM_SRC-1:0]        spec_ready_q;
  logic [NUM_SRC-1:0]        spec_used_q;
  logic [BR_W-1:0]           br_mask_q;
  logic                      except_q;
  logic [RC_W-1:0]           replay_q;

  logic                      put_now;
  logic [NUM_SRC-1:0]        cur_v, cur_r, cur_sr;
  logic [NUM_SRC*RNID_W-1:0] cur_rnid;
  logic [NUM_SRC-1:0]        ns_hit, sp_hit, cn_hit;
  logic [NUM_SRC-1:0]        rdy, srdy;
  logic                      spec_ok, all_rdy, kill, put_kill;
  logic                      replay_cancel, commit_hit, release_now;
  logic [BR_W-1:0]           br_clr;

  // On the put cycle the incoming fields stand in for the latched ones.
  assign put_now  = i_put & (state_q == S_INIT);
  assign cur_v    = put_now ? i_put_src_valid : src_valid_q;
  assign cur_r    = put_now ? i_put_src_ready : ready_q;
  assign cur_sr   = put_now ? '0 : spec_ready_q;
  assign cur_rnid = put_now ? i_put_src_rnid : src_rnid_q;
  assign spec_ok  = replay_q < RC_W'(REPLAY_MAX);

  always_comb begin
    ns_hit = '0;
    sp_hit = '0;
    cn_hit = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int w = 0; w < WAKE_NUM; w++) begin
        if (cur_v[k] && i_wake_valid[w] &&
            i_wake_rnid[w*RNID_W +: RNID_W] == cur_rnid[k*RNID_W +: RNID_W]) begin
          if (i_wake_spec[w]) begin
            if (spec_ok) sp_hit[k] = 1'b1;
          end else begin
            ns_hit[k] = 1'b1;
          end
        end
      end
      for (int c = 0; c < CANCEL_NUM; c++) begin
        if (cur_v[k] && i_cancel_valid[c] &&
            i_cancel_rnid[c*RNID_W +: RNID_W] == cur_rnid[k*RNID_W +: RNID_W])
          cn_hit[k] = 1'b1;
      end
    end
  end

  assign rdy           = cur_r | ns_hit;
  assign srdy          = (cur_sr | sp_hit) & ~cn_hit;
  assign all_rdy       = &(~cur_v | rdy | srdy);
  assign br_clr        = i_br_upd ? (BR_W'(1) << i_br_tag) : '0;
  assign kill          = i_flush | (i_br_upd & i_br_mispred & br_mask_q[i_br_tag]);
  assign put_kill      = i_br_upd & i_br_mispred & i_put_br_mask[i_br_tag];
  assign replay_cancel = |(cn_hit & spec_used_q);
  assign commit_hit    = i_commit & (i_commit_cmt_id == cmt_id_q);
  assign release_now   = commit_hit &
                         (state_q == S_DONE || state_q == S_WCMP || state_q == S_DEAD);

  assign o_valid      = valid_q;
  assign o_ready      = valid_q & (state_q == S_WAIT) & ~kill & all_rdy;
  assign o_src_ready  = valid_q ? (rdy | srdy) : '0;
  assign o_done       = (state_q == S_DONE);
  assign o_finish     = release_now;
  assign o_except     = except_q;
  assign o_replay_cnt = replay_q;
  assign o_cmt_id     = cmt_id_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= S_INIT;
      valid_q      <= 1'b0;
      cmt_id_q     <= '0;
      src_valid_q  <= '0;
      src_rnid_q   <= '0;
      ready_q      <= '0;
      spec_ready_q <= '0;
      spec_used_q  <= '0;
      br_mask_q    <= '0;
      except_q     <= 1'b0;
      replay_q     <= '0;
    end else begin
      br_mask_q    <= br_mask_q & ~br_clr;
      ready_q      <= rdy;
      spec_ready_q <= srdy;
      unique case (state_q)
        S_INIT: if (i_put) begin
          state_q     <= put_kill ? S_DEAD : S_WAIT;
          valid_q     <= 1'b1;
          cmt_id_q    <= i_put_cmt_id;
          src_valid_q <= i_put_src_valid;
          src_rnid_q  <= i_put_src_rnid;
          br_mask_q   <= i_put_br_mask & ~br_clr;
          spec_used_q <= '0;
          except_q    <= 1'b0;
        end
        S_WAIT: begin
          if (kill) state_q <= S_DEAD;
          else if (i_picked && o_ready) begin
            state_q     <= S_ISSUED;
            spec_used_q <= srdy & ~rdy & cur_v;
          end
        end
        S_ISSUED: begin
          if (kill) state_q <= S_DEAD;
          else if (replay_cancel) begin
            state_q      <= S_WAIT;
            spec_ready_q <= '0;
            spec_used_q  <= '0;
            if (spec_ok) replay_q <= replay_q + RC_W'(1);
          end else if (i_pipe_done) begin
            state_q  <= S_DONE;
            except_q <= i_pipe_except;
          end
        end
        S_DONE:  state_q <= kill ? S_DEAD : S_WCMP;
        S_WCMP, S_DEAD: ;
        default: state_q <= S_INIT;
      endcase
      if (release_now) begin
        state_q      <= S_INIT;
        valid_q      <= 1'b0;
        cmt_id_q     <= '0;
        src_valid_q  <= '0;
        ready_q      <= '0;
        spec_ready_q <= '0;
        spec_used_q  <= '0;
        except_q     <= 1'b0;
        replay_q     <= '0;
      end
    end
  end

  always_ff @(posedge i_clk)
    if (i_reset_n) assert (!(i_put && state_q != S_INIT));

endmodule

// File: tb/tb_msrh_sched_entry_multi_src.sv
// tb_msrh_sched_entry_multi_src: directed bench for the scheduler entry,
// covering wakeup, replay, kill, release and reset.
module tb_msrh_sched_entry_multi_src;
  localparam int NS = 3, WN = 4, CN = 2, RW = 7, CW = 6, BW = 8, RM = 3;
  localparam int RCW = $clog2(RM+1), TW = $clog2(BW);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            put;
  logic [CW-1:0]   put_cmt;
  logic [NS-1:0]   put_sv;
  logic [NS*RW-1:0] put_rn;
  logic [NS-1:0]   put_sr;
  logic [BW-1:0]   put_br;
  logic [WN-1:0]   wv;
  logic [WN*RW-1:0] wr;
  logic [WN-1:0]   ws;
  logic [CN-1:0]   cv;
  logic [CN*RW-1:0] cr;
  logic            picked, pdone, pexc, commit, flush, br_upd, mispred;
  logic [CW-1:0]   commit_id;
  logic [TW-1:0]   br_tag;
  logic            valid, ready, done, finish, except;
  logic [NS-1:0]   src_ready;
  logic [RCW-1:0]  replay;
  logic [CW-1:0]   cmt_id;

  int total = 0;
  int bad = 0;

  msrh_sched_entry_multi_src dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_put(put), .i_put_cmt_id(put_cmt),
    .i_put_src_valid(put_sv), .i_put_src_rnid(put_rn),
    .i_put_src_ready(put_sr), .i_put_br_mask(put_br),
    .i_wake_valid(wv), .i_wake_rnid(wr), .i_wake_spec(ws),
    .i_cancel_valid(cv), .i_cancel_rnid(cr),
    .i_picked(picked), .i_pipe_done(pdone), .i_pipe_except(pexc),
    .i_commit(commit), .i_commit_cmt_id(commit_id), .i_flush(flush),
    .i_br_upd(br_upd), .i_br_tag(br_tag), .i_br_mispred(mispred),
    .o_valid(valid), .o_ready(ready), .o_src_ready(src_ready),
    .o_done(done), .o_finish(finish), .o_except(except),
    .o_replay_cnt(replay), .o_cmt_id(cmt_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    put = 0; put_cmt = '0; put_sv = '0; put_rn = '0; put_sr = '0; put_br = '0;
    wv = '0; wr = '0; ws = '0; cv = '0; cr = '0;
    picked = 0; pdone = 0; pexc = 0; commit = 0; commit_id = '0;
    flush = 0; br_upd = 0; br_tag = '0; mispred = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_put(input int cmt, input logic [NS-1:0] sv,
                        input logic [NS*RW-1:0] rn, input logic [NS-1:0] sr,
                        input logic [BW-1:0] br);
    put = 1; put_cmt = CW'(cmt); put_sv = sv; put_rn = rn;
    put_sr = sr; put_br = br;
  endtask

  task automatic wake(input int w, input int rn, input logic sp);
    wv[w] = 1'b1; wr[w*RW +: RW] = RW'(rn); ws[w] = sp;
  endtask

  task automatic cancel(input int c, input int rn);
    cv[c] = 1'b1; cr[c*RW +: RW] = RW'(rn);
  endtask

  task automatic do_commit(input int id);
    commit = 1; commit_id = CW'(id);
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_finish", 32'(finish), 0);
    chk("rst_replay", 32'(replay), 0);
    chk("rst_cmt", 32'(cmt_id), 0);
    chk("rst_srcrdy", 32'(src_ready), 0);
    rst_n = 1;

    // three sources woken one per cycle, then issue/done/commit
    do_put(9, 3'b111, {7'd7, 7'd6, 7'd5}, 3'b000, 8'h00);
    #1 chk("t1_put_ready", 32'(ready), 0);
    cyc();
    chk("t1_valid", 32'(valid), 1);
    chk("t1_cmt", 32'(cmt_id), 9);
    wake(0, 5, 0);
    #1 chk("t1_c2_ready", 32'(ready), 0);
    chk("t1_c2_srcrdy", 32'(src_ready), 32'h1);
    cyc();
    wake(2, 6, 0);
    #1 chk("t1_c3_ready", 32'(ready), 0);
    cyc();
    wake(3, 7, 0); picked = 1;
    #1 chk("t1_c4_ready", 32'(ready), 1);
    cyc();
    chk("t1_iss_ready", 32'(ready), 0);
    pdone = 1;
    cyc();
    chk("t1_done", 32'(done), 1);
    cyc();
    chk("t1_wcmp_done", 32'(done), 0);
    do_commit(8);
    #1 chk("t1_wrong_commit", 32'(finish), 0);
    cyc();
    do_commit(9);
    #1 chk("t1_finish", 32'(finish), 1);
    cyc();
    chk("t1_rel_valid", 32'(valid), 0);
    chk("t1_rel_cmt", 32'(cmt_id), 0);

    // speculative wake, cancel, replay, non-spec reissue
    do_put(12, 3'b001, {7'd0, 7'd0, 7'd5}, 3'b000, 8'h00);
    cyc();
    wake(1, 5, 1); picked = 1;
    #1 chk("t2_spec_ready", 32'(ready), 1);
    cyc();
    cancel(0, 5);
    cyc();
    chk("t2_replay", 32'(replay), 1);
    chk("t2_wait_ready", 32'(ready), 0);
    wake(0, 5, 0); picked = 1;
    #1 chk("t2_ns_ready", 32'(ready), 1);
    cyc();
    pdone = 1;
    cyc();
    do_commit(12);
    #1 chk("t2_done_commit", 32'(finish), 1);
    cyc();
    chk("t2_rel_replay", 32'(replay), 0);

    // replay saturation
    do_put(20, 3'b001, {7'd0, 7'd0, 7'd33}, 3'b000, 8'h00);
    cyc();
    for (int i = 0; i < 3; i++) begin
      wake(i, 33, 1); picked = 1;
      cyc();
      cancel(1, 33);
      cyc();
      chk("t3_replay_step", 32'(replay), 32'(i + 1));
    end
    wake(2, 33, 1);
    #1 chk("t3_sat_ready", 32'(ready), 0);
    chk("t3_sat_srcrdy", 32'(src_ready), 0);
    cyc();
    chk("t3_sat_idle", 32'(ready), 0);
    wake(1, 33, 0);
    #1 chk("t3_ns_ready", 32'(ready), 1);
    cyc();
    chk("t3_latched_ready", 32'(ready), 1);
    flush = 1;
    #1 chk("t3_flush_ready", 32'(ready), 0);
    cyc();
    chk("t3_dead_valid", 32'(valid), 1);
    do_commit(20);
    #1 chk("t3_dead_finish", 32'(finish), 1);
    cyc();

    // mispredict kill in ISSUED
    do_put(30, 3'b000, '0, 3'b000, 8'h04);
    cyc();
    picked = 1;
    #1 chk("t4_nosrc_ready", 32'(ready), 1);
    cyc();
    br_upd = 1; br_tag = 3'd2; mispred = 1;
    cyc();
    chk("t4_dead_done", 32'(done), 0);
    chk("t4_dead_ready", 32'(ready), 0);
    chk("t4_dead_valid", 32'(valid), 1);
    do_commit(30);
    #1 chk("t4_finish", 32'(finish), 1);
    cyc();
    chk("t4_rel_valid", 32'(valid), 0);

    // correct prediction clears the mask bit
    do_put(31, 3'b000, '0, 3'b000, 8'h04);
    cyc();
    br_upd = 1; br_tag = 3'd2; mispred = 0;
    #1 chk("t4b_ok_ready", 32'(ready), 1);
    cyc();
    br_upd = 1; br_tag = 3'd2; mispred = 1; picked = 1;
    #1 chk("t4b_nokill_ready", 32'(ready), 1);
    cyc();
    chk("t4b_iss_valid", 32'(valid), 1);
    pdone = 1; pexc = 1;
    cyc();
    chk("t4b_done", 32'(done), 1);
    chk("t4b_except", 32'(except), 1);
    do_commit(31);
    #1 chk("t4b_finish", 32'(finish), 1);
    cyc();
    chk("t4b_rel_except", 32'(except), 0);

    // put coinciding with a mispredict of its own mask bit
    do_put(40, 3'b000, '0, 3'b000, 8'h10);
    br_upd = 1; br_tag = 3'd4; mispred = 1;
    cyc();
    chk("t5_valid", 32'(valid), 1);
    chk("t5_ready", 32'(ready), 0);
    cyc();
    chk("t5_ready2", 32'(ready), 0);
    do_commit(40);
    #1 chk("t5_finish", 32'(finish), 1);
    cyc();

    // cancel beats done, then reset while issued
    do_put(50, 3'b011, {7'd0, 7'd11, 7'd10}, 3'b010, 8'h00);
    cyc();
    wake(0, 10, 1); picked = 1;
    #1 chk("t6_spec_ready", 32'(ready), 1);
    cyc();
    cancel(0, 10); pdone = 1;
    cyc();
    chk("t6_not_done", 32'(done), 0);
    chk("t6_replay", 32'(replay), 1);
    chk("t6_wait_ready", 32'(ready), 0);
    chk("t6_srcrdy", 32'(src_ready), 32'h2);
    wake(3, 10, 0); picked = 1;
    cyc();
    chk("t6_iss_cmt", 32'(cmt_id), 50);
    rst_n = 0;
    cyc();
    chk("t6_rst_valid", 32'(valid), 0);
    chk("t6_rst_ready", 32'(ready), 0);
    chk("t6_rst_srcrdy", 32'(src_ready), 0);
    chk("t6_rst_replay", 32'(replay), 0);
    chk("t6_rst_cmt", 32'(cmt_id), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_except", 32'(except), 0);
    chk("t6_rst_finish", 32'(finish), 0);
    rst_n = 1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
